// File: rtl/velocity_ctrl_integrator_reset_sequencer.sv
// Integrator-reset sequencer for the velocity loop: IDLE -> PRECHARGE (hold) -> RUN, with FAULT latch.
// Optional integrator saturation monitor enabled by macro VELOCITY_CTRL_SAT_MONITOR_EN.
module velocity_ctrl_integrator_reset_sequencer #(
  parameter int                 HOLD_TICKS = 4,
  parameter int                 CNT_W      = 16,
  parameter logic signed [31:0] SAT_LIMIT  = 32'sd1000000,
  parameter int                 SAT_TICKS  = 8
) (
  input  logic               CLK_IN,
  input  logic               reset_n,
  input  logic               enb_1_2000_0,
  input  logic               loop_enable,
  input  logic               fault,
  input  logic               fault_clear,
  input  logic signed [31:0] In,
  output logic               Reset_1,
  output logic               loop_active,
  output logic               fault_latched,
  output logic               sat_flag,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_PRECHARGE = 2'b01,
    S_RUN       = 2'b10,
    S_FAULT     = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic             r_sat_flag;
  logic             w_sat_flag_nxt;
  logic             w_sat_trip;
  logic             r_reset1;
  logic             r_loop_active;
  logic             r_fault_latched;

`ifdef VELOCITY_CTRL_SAT_MONITOR_EN
  logic [CNT_W-1:0] r_sat_cnt;
  logic [CNT_W-1:0] w_sat_cnt_nxt;
  logic             w_over;

  // 33-bit magnitude so that -2^31 maps to +2^31 instead of wrapping.
  function automatic logic [32:0] f_abs33(input logic signed [31:0] x);
    logic [32:0] ext;
    ext = {x[31], x};
    f_abs33 = x[31] ? (33'd0 - ext) : ext;
  endfunction

  assign w_over     = f_abs33(In) > {1'b0, SAT_LIMIT};
  assign w_sat_trip = (r_state == S_RUN) && w_over &&
                      (r_sat_cnt == CNT_W'(SAT_TICKS - 1));

  always_comb begin
    w_sat_cnt_nxt = '0;
    if (r_state == S_RUN && w_over) begin
      w_sat_cnt_nxt = (r_sat_cnt == {CNT_W{1'b1}}) ? r_sat_cnt : r_sat_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_cnt <= '0;
    end else if (enb_1_2000_0) begin
      r_sat_cnt <= w_sat_cnt_nxt;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^{In, SAT_LIMIT}) ^ (SAT_TICKS > 0);
  assign w_sat_trip   = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold_cnt;
    w_sat_flag_nxt = r_sat_flag;
    case (r_state)
      S_IDLE: begin
        if (fault) begin
          w_state_nxt = S_FAULT;
        end else if (loop_enable) begin
          w_state_nxt = S_PRECHARGE;
          w_hold_nxt  = '0;
        end
      end
      S_PRECHARGE: begin
        if (fault) begin
          w_state_nxt = S_FAULT;
        end else if (!loop_enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_hold_cnt == CNT_W'(HOLD_TICKS - 1)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (fault || w_sat_trip) begin
          w_state_nxt = S_FAULT;
          if (w_sat_trip) w_sat_flag_nxt = 1'b1;
        end else if (!loop_enable) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        // loop_enable is deliberately ignored here; restart always goes through IDLE.
        if (fault_clear && !fault) begin
          w_state_nxt    = S_IDLE;
          w_sat_flag_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_hold_cnt      <= '0;
      r_sat_flag      <= 1'b0;
      r_reset1        <= 1'b1;
      r_loop_active   <= 1'b0;
      r_fault_latched <= 1'b0;
    end else if (enb_1_2000_0) begin
      r_state         <= w_state_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_sat_flag      <= w_sat_flag_nxt;
      r_reset1        <= (w_state_nxt != S_RUN);
      r_loop_active   <= (w_state_nxt == S_RUN);
      r_fault_latched <= (w_state_nxt == S_FAULT);
    end
  end

  assign Reset_1       = r_reset1;
  assign loop_active   = r_loop_active;
  assign fault_latched = r_fault_latched;
  assign sat_flag      = r_sat_flag;
  assign state         = r_state;

endmodule

// File: tb/tb_velocity_ctrl_integrator_reset_sequencer.sv
// Directed bench for the velocity-loop integrator reset sequencer.
module tb_velocity_ctrl_integrator_reset_sequencer;

  logic               CLK_IN = 1'b0;
  logic               reset_n;
  logic               enb_1_2000_0;
  logic               loop_enable;
  logic               fault;
  logic               fault_clear;
  logic signed [31:0] In;
  logic               Reset_1;
  logic               loop_active;
  logic               fault_latched;
  logic               sat_flag;
  logic [1:0]         state;

  int n_chk  = 0;
  int n_pass = 0;

  // {state, Reset_1, loop_active, fault_latched, sat_flag}
  localparam logic [5:0] V_IDLE  = 6'b00_1000;
  localparam logic [5:0] V_PRE   = 6'b01_1000;
  localparam logic [5:0] V_RUN   = 6'b10_0100;
  localparam logic [5:0] V_FAULT = 6'b11_1010;
  localparam logic [5:0] V_FSAT  = 6'b11_1011;

  velocity_ctrl_integrator_reset_sequencer dut (
    .CLK_IN        (CLK_IN),
    .reset_n       (reset_n),
    .enb_1_2000_0  (enb_1_2000_0),
    .loop_enable   (loop_enable),
    .fault         (fault),
    .fault_clear   (fault_clear),
    .In            (In),
    .Reset_1       (Reset_1),
    .loop_active   (loop_active),
    .fault_latched (fault_latched),
    .sat_flag      (sat_flag),
    .state         (state)
  );

  always #5 CLK_IN = ~CLK_IN;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {state, Reset_1, loop_active, fault_latched, sat_flag};
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  // One rate tick, then three non-tick clocks; returns at a negedge.
  task automatic tick();
    @(negedge CLK_IN);
    enb_1_2000_0 = 1'b1;
    @(negedge CLK_IN);
    enb_1_2000_0 = 1'b0;
    repeat (3) @(negedge CLK_IN);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n      = 1'b0;
    enb_1_2000_0 = 1'b0;
    loop_enable  = 1'b0;
    fault        = 1'b0;
    fault_clear  = 1'b0;
    In           = '0;
    repeat (3) @(negedge CLK_IN);
    chk("reset_state", V_IDLE);
    reset_n = 1'b1;
    tick();
    chk("idle_no_enable", V_IDLE);

    // Start-up: 4 ticks in PRECHARGE, RUN after the 4th.
    loop_enable = 1'b1;
    tick();
    chk("enter_pre", V_PRE);
    ticks(3);
    chk("pre_after_3", V_PRE);
    @(negedge CLK_IN);
    enb_1_2000_0 = 1'b1;
    @(posedge CLK_IN);
    #1;
    chk("run_one_clk_after_4th", V_RUN);
    @(negedge CLK_IN);
    enb_1_2000_0 = 1'b0;
    tick();
    chk("run_stays", V_RUN);

    // Asynchronous reset mid-RUN.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_midrun", V_IDLE);
    @(negedge CLK_IN);
    reset_n = 1'b1;

    // Abort after two PRECHARGE ticks, then full hold again.
    tick();
    chk("abort_enter_pre", V_PRE);
    ticks(2);
    chk("abort_pre_2", V_PRE);
    loop_enable = 1'b0;
    tick();
    chk("abort_to_idle", V_IDLE);
    loop_enable = 1'b1;
    tick();
    chk("reenter_pre", V_PRE);
    ticks(3);
    chk("rehold_full_pre", V_PRE);
    tick();
    chk("rehold_run", V_RUN);

    // Gating: input changes without a tick have no effect.
    fault       = 1'b1;
    loop_enable = 1'b0;
    repeat (6) @(negedge CLK_IN);
    chk("gated_no_change", V_RUN);

    // Fault has priority over loop_enable drop.
    tick();
    chk("fault_priority", V_FAULT);
    fault_clear = 1'b1;
    tick();
    chk("clear_while_fault", V_FAULT);
    fault       = 1'b0;
    fault_clear = 1'b0;
    loop_enable = 1'b1;
    tick();
    chk("fault_ignores_enable", V_FAULT);
    fault_clear = 1'b1;
    tick();
    chk("fault_cleared", V_IDLE);
    fault_clear = 1'b0;
    tick();
    chk("restart_pre", V_PRE);
    ticks(4);
    chk("restart_run", V_RUN);

`ifdef VELOCITY_CTRL_SAT_MONITOR_EN
    In = 32'sd1000001;
    ticks(7);
    chk("over_7_no_trip", V_RUN);
    In = 32'sd999999;
    tick();
    chk("under_resets_cnt", V_RUN);
    In = 32'sh8000_0000;
    ticks(7);
    chk("minneg_7", V_RUN);
    tick();
    chk("minneg_8_trip", V_FSAT);
    In = '0;
    fault_clear = 1'b1;
    tick();
    chk("sat_clear_idle", V_IDLE);
    fault_clear = 1'b0;
`else
    In = 32'sh8000_0000;
    ticks(10);
    chk("off_minneg_no_trip", V_RUN);
    In = 32'sh7FFF_FFFF;
    ticks(10);
    chk("off_maxpos_no_trip", V_RUN);
    In = '0;
`endif

    loop_enable = 1'b0;
    tick();
    chk("final_idle", V_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
